// File: rtl/param_mapper.sv
`default_nettype none
// ============================================================================
// param_mapper : frame mapper (overhead / client payload / CRC-8 byte).
// Optional CRC insertion enabled by macro PARAM_MAPPER_CRC_EN.  Rev 1.0
// ============================================================================
module param_mapper #(
  parameter int ROWS    = 4,
  parameter int COLS    = 1024,
  parameter int OH_COLS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_pyld_data,
  input  logic       i_pyld_data_valid,
  output logic       o_pyld_data_req,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  output logic       o_frame_sof,
  input  logic       i_line_ready,
  input  logic       i_line_retrans_req,
  input  logic       i_arq_en,
  output logic [7:0] o_crc_val,
  output logic [7:0] o_frame_cnt
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_PRE_CRC = CW'(COLS - 2);
  localparam logic [CW-1:0] COL_OH_LAST = CW'(OH_COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OH   = 2'd1,
    PYLD = 2'd2,
    CRC  = 2'd3
  } state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          arq_q;
  logic [7:0]    oh_byte;
  logic [7:0]    crc_byte;
  logic          advance;
  logic          accept;
  logic          first_pos;

  assign advance         = !o_frame_data_valid || i_line_ready;
  assign o_pyld_data_req = (state == PYLD) && advance && !i_rst;
  assign accept          = o_pyld_data_req && i_pyld_data_valid;
  assign first_pos       = (row == '0) && (col == '0);

  always_comb begin
    oh_byte = 8'h00;
    if (row == '0) begin
      if (col == CW'(0))      oh_byte = 8'hF6;
      else if (col == CW'(1)) oh_byte = 8'h28;
      else if (col == CW'(2)) oh_byte = o_frame_cnt;
      else if (col == CW'(3)) oh_byte = {7'b0, arq_q};
    end
  end

`ifdef PARAM_MAPPER_CRC_EN
  logic [7:0] crc;

  // CRC-8, poly 0x07, MSB first, one whole byte per call
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    c = crc_in ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc       <= 8'h00;
      o_crc_val <= 8'h00;
    end else if (advance) begin
      if (state == OH && first_pos) crc <= 8'h00;
      else if (accept)              crc <= crc8_byte(crc, i_pyld_data);
      if (state == CRC)             o_crc_val <= crc;
    end
  end

  assign crc_byte = crc;
`else
  assign crc_byte  = 8'h00;
  assign o_crc_val = 8'h00;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      row                <= '0;
      col                <= '0;
      arq_q              <= 1'b0;
      o_frame_data       <= 8'h00;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_frame_sof        <= 1'b0;
      o_frame_cnt        <= 8'h00;
    end else if (advance) begin
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_frame_sof        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_pyld_data_valid && !i_line_retrans_req) begin
            state <= OH;
            row   <= '0;
            col   <= '0;
          end
        end
        OH: begin
          o_frame_data       <= oh_byte;
          o_frame_data_valid <= 1'b1;
          o_frame_data_fas   <= (row == '0) && (col < CW'(2));
          if (first_pos) begin
            o_frame_sof <= 1'b1;
            arq_q       <= i_arq_en;
          end
          if (col == COL_OH_LAST) state <= PYLD;
          col <= col + 1'b1;
        end
        PYLD: begin
          // position only moves when a client byte is actually taken
          if (i_pyld_data_valid) begin
            o_frame_data       <= i_pyld_data;
            o_frame_data_valid <= 1'b1;
            if (row == ROW_LAST && col == COL_PRE_CRC) begin
              state <= CRC;
              col   <= col + 1'b1;
            end else if (col == COL_LAST) begin
              state <= OH;
              col   <= '0;
              row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        CRC: begin
          o_frame_data       <= crc_byte;
          o_frame_data_valid <= 1'b1;
          o_frame_cnt        <= o_frame_cnt + 8'd1;
          row                <= '0;
          col                <= '0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_mapper.sv
`default_nettype none
// ============================================================================
// tb_param_mapper : directed self-checking bench for param_mapper (2x9 frames).
// Rev 1.0
// ============================================================================
module tb_param_mapper;

`ifdef PARAM_MAPPER_CRC_EN
  localparam logic [7:0] CRC_EXP = 8'hF4;
`else
  localparam logic [7:0] CRC_EXP = 8'h00;
`endif
  localparam int FLEN = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pyld_data;
  logic       pyld_valid;
  logic       pyld_req;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_fas;
  logic       frame_sof;
  logic       line_ready;
  logic       retrans;
  logic       arq_en;
  logic [7:0] crc_val;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] src[$];
  logic [7:0] out_q[$];
  logic       sof_q[$];
  logic       fas_q[$];
  logic       valid_en;
  logic       ready_toggle;
  logic       accept_pend;
  logic       hold_pend;
  logic [7:0] held;
  int         gap_cnt;

  param_mapper #(.ROWS(2), .COLS(9), .OH_COLS(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pyld_data        (pyld_data),
    .i_pyld_data_valid  (pyld_valid),
    .o_pyld_data_req    (pyld_req),
    .o_frame_data       (frame_data),
    .o_frame_data_valid (frame_valid),
    .o_frame_data_fas   (frame_fas),
    .o_frame_sof        (frame_sof),
    .i_line_ready       (line_ready),
    .i_line_retrans_req (retrans),
    .i_arq_en           (arq_en),
    .o_crc_val          (crc_val),
    .o_frame_cnt        (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // one clock: retire last cycle's handshakes, drive new inputs, record what transfers next
  task automatic step();
    @(negedge clk);
    if (accept_pend && src.size() > 0) void'(src.pop_front());
    if (hold_pend) check("hold", {23'b0, frame_valid, frame_data}, {23'b0, 1'b1, held});
    if (!frame_valid && out_q.size() > 0 && out_q.size() < FLEN) gap_cnt++;
    line_ready = ready_toggle ? ~line_ready : 1'b1;
    pyld_valid = valid_en && (src.size() > 0);
    pyld_data  = (src.size() > 0) ? src[0] : 8'h00;
    #1;
    accept_pend = pyld_req && pyld_valid;
    if (frame_valid && line_ready) begin
      out_q.push_back(frame_data);
      sof_q.push_back(frame_sof);
      fas_q.push_back(frame_fas);
    end
    hold_pend = frame_valid && !line_ready;
    held      = frame_data;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && out_q.size() < n; k++) step();
  endtask

  task automatic clear_q();
    out_q.delete();
    sof_q.delete();
    fas_q.delete();
  endtask

  task automatic load_payload();
    for (int k = 0; k < 9; k++) src.push_back(8'h31 + 8'(k));
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] fnum, input logic arq);
    logic [7:0]  exp_b[FLEN];
    logic [17:0] sof_v;
    logic [17:0] fas_v;
    for (int i = 0; i < FLEN; i++) exp_b[i] = 8'h00;
    exp_b[0] = 8'hF6;
    exp_b[1] = 8'h28;
    exp_b[2] = fnum;
    exp_b[3] = {7'b0, arq};
    for (int k = 0; k < 5; k++) exp_b[4 + k]  = 8'h31 + 8'(k);
    for (int k = 0; k < 4; k++) exp_b[13 + k] = 8'h36 + 8'(k);
    exp_b[17] = CRC_EXP;
    check({tag, "_len"}, out_q.size(), FLEN);
    sof_v = '0;
    fas_v = '0;
    for (int i = 0; i < FLEN; i++) begin
      if (i < out_q.size()) begin
        check($sformatf("%s_b%0d", tag, i), {24'b0, out_q[i]}, {24'b0, exp_b[i]});
        sof_v[i] = sof_q[i];
        fas_v[i] = fas_q[i];
      end
    end
    check({tag, "_sof"}, {14'b0, sof_v}, 32'h1);
    check({tag, "_fas"}, {14'b0, fas_v}, 32'h3);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    check("rst_outs", {20'b0, frame_data, frame_valid, frame_fas, frame_sof, pyld_req}, 32'h0);
    rst = 1'b0;
    src.delete();
    clear_q();
    pyld_valid  = 1'b0;
    accept_pend = 1'b0;
    hold_pend   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pyld_data = 8'h00; pyld_valid = 1'b0; line_ready = 1'b1;
    retrans = 1'b0; arq_en = 1'b0; valid_en = 1'b1; ready_toggle = 1'b0;
    accept_pend = 1'b0; hold_pend = 1'b0; held = 8'h00; gap_cnt = 0;

    // reset state
    repeat (3) step();
    check("rst_outs", {20'b0, frame_data, frame_valid, frame_fas, frame_sof, pyld_req}, 32'h0);
    check("rst_crc", {24'b0, crc_val}, 32'h0);
    check("rst_cnt", {24'b0, frame_cnt}, 32'h0);
    rst = 1'b0;
    step();

    // continuous frame
    clear_q(); load_payload();
    run_until(FLEN, 200);
    expect_frame("basic", 8'h00, 1'b0);
    check("basic_crcval", {24'b0, crc_val}, {24'b0, CRC_EXP});
    check("basic_cnt", {24'b0, frame_cnt}, 32'h1);

    // line back-pressure every other cycle
    clear_q(); load_payload(); ready_toggle = 1'b1;
    run_until(FLEN, 400);
    ready_toggle = 1'b0;
    expect_frame("toggle", 8'h01, 1'b0);

    // client data gap of three cycles mid-row
    step(); step();
    clear_q(); load_payload(); gap_cnt = 0;
    run_until(6, 200);
    valid_en = 1'b0;
    repeat (3) step();
    valid_en = 1'b1;
    run_until(FLEN, 200);
    expect_frame("gap", 8'h02, 1'b0);
    check("gap_cycles", gap_cnt, 3);

    // retransmit request holds the next frame in IDLE, ignored once started
    step(); step();
    clear_q(); load_payload(); retrans = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("retrans_idle", {29'b0, frame_sof, frame_valid, pyld_req}, 32'h0);
    end
    retrans = 1'b0;
    run_until(8, 200);
    retrans = 1'b1;
    run_until(FLEN, 200);
    retrans = 1'b0;
    expect_frame("retrans", 8'h03, 1'b0);

    // reset at row1 col5 discards the partial frame
    step(); step();
    clear_q(); load_payload();
    run_until(14, 200);
    check("mid_reach", {31'b0, out_q.size() >= 14}, 32'h1);
    pulse_reset();
    check("mid_rst_cnt", {24'b0, frame_cnt}, 32'h0);
    check("mid_rst_crc", {24'b0, crc_val}, 32'h0);
    load_payload();
    run_until(FLEN, 200);
    expect_frame("restart", 8'h00, 1'b0);
    check("restart_crcval", {24'b0, crc_val}, {24'b0, CRC_EXP});
    check("restart_cnt", {24'b0, frame_cnt}, 32'h1);

    // 257 frames with ARQ: frame number wraps
    step();
    pulse_reset();
    arq_en = 1'b1;
    for (int f = 0; f < 257; f++) begin
      load_payload();
      run_until(FLEN, 200);
      check("arq_len", out_q.size(), FLEN);
      if (out_q.size() >= FLEN) begin
        check($sformatf("arq_col2_f%0d", f), {24'b0, out_q[2]}, {24'b0, 8'(f)});
        check("arq_col3", {24'b0, out_q[3]}, 32'h1);
        check("arq_crc", {24'b0, out_q[17]}, {24'b0, CRC_EXP});
        check("arq_sof", {31'b0, sof_q[0]}, 32'h1);
      end
      clear_q();
    end
    check("arq_cnt_wrap", {24'b0, frame_cnt}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
